// File: rtl/blk_cipher_ctrl_pkg.sv
// Shared types and constants for the receive-RAM -> block cipher -> transmit-RAM
// controller.
package blk_cipher_ctrl_pkg;

  localparam int DEF_ADDR_W   = 10;
  localparam int NIB_PER_WORD = 16;
  localparam int NIB_W        = 4;
  localparam int WORD_W       = NIB_PER_WORD * NIB_W;
  localparam int CNT_W        = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_STORE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Number of 64-bit cipher words held in a RAM of 2**addr_w nibbles.
  function automatic int words_per_block(input int addr_w);
    return 2 ** (addr_w - $clog2(NIB_PER_WORD));
  endfunction

endpackage

// File: rtl/blk_cipher_ctrl_if.sv
// Control, RAM and cipher-core signals of blk_cipher_ctrl; master is the
// controller side, slave the surrounding driver / RAMs / cipher core.
interface blk_cipher_ctrl_if
  import blk_cipher_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              istart;
  logic              obusy;
  logic              odone;

  logic [ADDR_W-1:0] oraddr;
  logic [NIB_W-1:0]  irdata;

  logic [ADDR_W-1:0] owaddr;
  logic [NIB_W-1:0]  owdata;
  logic              owen;

  logic              ocipher_start;
  logic [WORD_W-1:0] ocipher_data;
  logic              icipher_done;
  logic [WORD_W-1:0] icipher_data;

  modport master (
    input  istart,
    input  irdata,
    input  icipher_done,
    input  icipher_data,
    output obusy,
    output odone,
    output oraddr,
    output owaddr,
    output owdata,
    output owen,
    output ocipher_start,
    output ocipher_data
  );

  modport slave (
    output istart,
    output irdata,
    output icipher_done,
    output icipher_data,
    input  obusy,
    input  odone,
    input  oraddr,
    input  owaddr,
    input  owdata,
    input  owen,
    input  ocipher_start,
    input  ocipher_data
  );

endinterface

// File: rtl/blk_cipher_ctrl_nib_pack64.sv
// 64-bit nibble packer (MSB nibble first) and result-register nibble extractor.
// Both expose their next-cycle value so the caller can register outputs in step.
module nib_pack64
  import blk_cipher_ctrl_pkg::*;
(
  input  logic              iclk,
  input  logic              irst,
  input  logic              shift_en,
  input  logic [NIB_W-1:0]  din,
  output logic [WORD_W-1:0] pack_next,
  input  logic              res_load,
  input  logic [WORD_W-1:0] res_in,
  input  logic [3:0]        idx,
  output logic [NIB_W-1:0]  nib_next
);

  logic [WORD_W-1:0] pack_reg;
  logic [WORD_W-1:0] res_reg;
  logic [WORD_W-1:0] res_next;
  logic [NIB_W-1:0]  nib_arr [NIB_PER_WORD];

  assign pack_next = shift_en ? {pack_reg[WORD_W-NIB_W-1:0], din} : pack_reg;
  assign res_next  = res_load ? res_in : res_reg;

  always_ff @(posedge iclk) begin
    if (irst) begin
      pack_reg <= '0;
      res_reg  <= '0;
    end else begin
      pack_reg <= pack_next;
      res_reg  <= res_next;
    end
  end

  // Index 0 selects the most significant nibble.
  generate
    for (genvar gi = 0; gi < NIB_PER_WORD; gi++) begin : g_nib
      assign nib_arr[gi] = res_next[WORD_W-1-NIB_W*gi -: NIB_W];
    end
  endgenerate

  assign nib_next = nib_arr[idx];

endmodule

// File: rtl/blk_cipher_ctrl.sv
// Reads a received block nibble by nibble, ciphers it one 64-bit word at a time
// and writes the result into the transmit RAM, then pulses odone.
module blk_cipher_ctrl
  import blk_cipher_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
)(
  input  logic              iclk,
  input  logic              irst,
  blk_cipher_ctrl_if.master bus
);

  localparam int                BLK_W      = ADDR_W - $clog2(NIB_PER_WORD);
  localparam int                NBLK       = words_per_block(ADDR_W);
  localparam logic [BLK_W-1:0]  BLK_LAST   = BLK_W'(NBLK - 1);
  localparam logic [CNT_W-1:0]  N_LOAD_END = CNT_W'(NIB_PER_WORD);
  localparam logic [CNT_W-1:0]  N_NIB_LAST = CNT_W'(NIB_PER_WORD - 1);

  state_e             state_reg, state_next;
  logic [CNT_W-1:0]   n_reg, n_next;
  logic [BLK_W-1:0]   blk_reg, blk_next;

  logic               obusy_reg, obusy_next;
  logic               odone_reg, odone_next;
  logic [ADDR_W-1:0]  oraddr_reg, oraddr_next;
  logic [ADDR_W-1:0]  owaddr_reg, owaddr_next;
  logic [NIB_W-1:0]   owdata_reg, owdata_next;
  logic               owen_reg, owen_next;
  logic               cstart_reg, cstart_next;
  logic [WORD_W-1:0]  cdata_reg, cdata_next;

  logic               shift_en;
  logic               res_load;
  logic [WORD_W-1:0]  pack_next;
  logic [NIB_W-1:0]   nib_next;

  // Read data lags the address by one cycle, so LOAD n shifts in nibble n-1.
  assign shift_en = (state_reg == ST_LOAD) && (n_reg != '0);
  assign res_load = (state_reg == ST_WAIT) && bus.icipher_done;

  nib_pack64 u_pack (
    .iclk      (iclk),
    .irst      (irst),
    .shift_en  (shift_en),
    .din       (bus.irdata),
    .pack_next (pack_next),
    .res_load  (res_load),
    .res_in    (bus.icipher_data),
    .idx       (n_next[3:0]),
    .nib_next  (nib_next)
  );

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_reg  <= ST_IDLE;
      n_reg      <= '0;
      blk_reg    <= '0;
      obusy_reg  <= 1'b0;
      odone_reg  <= 1'b0;
      oraddr_reg <= '0;
      owaddr_reg <= '0;
      owdata_reg <= '0;
      owen_reg   <= 1'b0;
      cstart_reg <= 1'b0;
      cdata_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      n_reg      <= n_next;
      blk_reg    <= blk_next;
      obusy_reg  <= obusy_next;
      odone_reg  <= odone_next;
      oraddr_reg <= oraddr_next;
      owaddr_reg <= owaddr_next;
      owdata_reg <= owdata_next;
      owen_reg   <= owen_next;
      cstart_reg <= cstart_next;
      cdata_reg  <= cdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    n_next     = n_reg;
    blk_next   = blk_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.istart) begin
          state_next = ST_LOAD;
          n_next     = '0;
          blk_next   = '0;
        end
      end
      ST_LOAD: begin
        if (n_reg == N_LOAD_END) begin
          state_next = ST_START;
          n_next     = '0;
        end else begin
          n_next = n_reg + 1'b1;
        end
      end
      ST_START: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.icipher_done) begin
          state_next = ST_STORE;
          n_next     = '0;
        end
      end
      ST_STORE: begin
        if (n_reg == N_NIB_LAST) begin
          n_next = '0;
          if (blk_reg == BLK_LAST) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_LOAD;
            blk_next   = blk_reg + 1'b1;
          end
        end else begin
          n_next = n_reg + 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        n_next     = '0;
        blk_next   = '0;
      end
    endcase
  end

  // Outputs are computed from the next state so that, once registered, they
  // line up with the state they belong to.
  always_comb begin
    obusy_next  = (state_next != ST_IDLE);
    odone_next  = (state_next == ST_DONE);
    cstart_next = (state_next == ST_START);
    owen_next   = (state_next == ST_STORE);
    cdata_next  = cdata_reg;
    oraddr_next = oraddr_reg;
    owaddr_next = owaddr_reg;
    owdata_next = owdata_reg;
    if (state_next == ST_START) begin
      cdata_next = pack_next;
    end
    if ((state_next == ST_LOAD) && (n_next != N_LOAD_END)) begin
      oraddr_next = {blk_next, n_next[3:0]};
    end
    if (state_next == ST_STORE) begin
      owaddr_next = {blk_next, n_next[3:0]};
      owdata_next = nib_next;
    end
  end

  assign bus.obusy         = obusy_reg;
  assign bus.odone         = odone_reg;
  assign bus.oraddr        = oraddr_reg;
  assign bus.owaddr        = owaddr_reg;
  assign bus.owdata        = owdata_reg;
  assign bus.owen          = owen_reg;
  assign bus.ocipher_start = cstart_reg;
  assign bus.ocipher_data  = cdata_reg;

endmodule

// File: doc/blk_cipher_ctrl.md
Name: blk_cipher_ctrl

Overview:
- Sits between the two RAMs that the SD D-line driver uses: the receive RAM (written by the driver after a block arrives) and the transmit RAM (read by the driver when it sends).
- After a block is received, it reads the 512-byte payload nibble by nibble and packs it into 64-bit words.
- It passes each word through the external 64-bit block-cipher core and writes the result back as nibbles into the transmit RAM.
- It then signals the driver that the block can be sent.

Parameters:
- ADDR_W, 10, nibble address width; RAM depth is 2**ADDR_W nibbles.
- NBLK, 2**(ADDR_W-4), number of 64-bit cipher words per data block; derived, not overridden.

Ports:
- iclk  input  1  SD clock
- irst  input  1  synchronous active-high reset
- istart  input  1  start processing; sampled only in IDLE
- obusy  output  1  high in every state except IDLE
- odone  output  1  one-cycle pulse after the last nibble is written; drives the driver's start-write input
- oraddr  output  ADDR_W  receive-RAM read address
- irdata  input  4  receive-RAM read data, valid one cycle after oraddr
- owaddr  output  ADDR_W  transmit-RAM write address
- owdata  output  4  transmit-RAM write data
- owen  output  1  transmit-RAM write enable
- ocipher_start  output  1  one-cycle pulse; ocipher_data is valid when it is high
- ocipher_data  output  64  packed plaintext word
- icipher_done  input  1  cipher result valid; single-cycle pulse
- icipher_data  input  64  cipher result word

Behaviour:
- Reset: state=IDLE; block index blk=0; nibble counter n=0. Outputs: odone=0, owen=0, ocipher_start=0, obusy=0, oraddr=0, owaddr=0, ocipher_data=0.
- Reset mid-operation aborts immediately. No further RAM writes occur; partially written transmit RAM is left as is.
- Nibble order: address {blk,k}, k=0..15, maps to word bits [63-4k -: 4]. The first nibble read is the MSB nibble, matching SD MSB-first order.
- IDLE:
  - istart=1 moves to LOAD with blk=0, n=0.
  - istart while not IDLE is ignored.
- LOAD, 17 cycles, n=0..16:
  - For n<=15, oraddr={blk,n[3:0]}.
  - For n>=1, shift irdata into the low end of the 64-bit pack register (reg <= {reg[59:0], irdata}).
  - At n=16, go to START.
- START, 1 cycle:
  - ocipher_start=1, ocipher_data=pack register. Go to WAIT.
  - icipher_done in this cycle is ignored.
- WAIT:
  - On icipher_done=1, latch icipher_data into the result register, set n=0, go to STORE.
  - No timeout.
- STORE, 16 cycles, n=0..15:
  - owen=1, owaddr={blk,n}, owdata=result[63-4n -: 4]; all registered.
  - After n=15: if blk==NBLK-1, go to DONE; otherwise increment blk, set n=0, go to LOAD.
- DONE, 1 cycle: odone=1, then go to IDLE.
- Cycles per word: 17 + 1 + L + 16, where L is cycles from ocipher_start to icipher_done (L>=1).
- Counters: blk wraps naturally at NBLK; it is never incremented past NBLK-1. n is 5 bits to cover 16.
- icipher_done outside WAIT is ignored. Output registers hold their last value when not in use; owen is 0 outside STORE.
- No write occurs to a transmit-RAM address before all 16 nibbles of that word have been read. RAM read and write ports are independent.

Decomposition:
- Shared package: state encoding (IDLE, LOAD, START, WAIT, STORE, DONE), NIB_PER_WORD=16, WORD_W=64, the default ADDR_W.
- One sub-module, nib_pack64: 64-bit shift-in packer plus indexed 4-bit extractor from the result register. Keeps the FSM file to FSM and counters only.

Test Plan:
- Ordering: receive RAM addresses 0..15 = 1,2,...,F,0 -> at the first ocipher_start, ocipher_data=64'h123456789ABCDEF0.
- Unpacking: the cipher model returns 64'hFEDCBA9876543210 -> transmit RAM addresses 0..15 = F,E,...,0, owen high for exactly 16 cycles.
- Loopback: identity cipher with L=1, random 1024-nibble RAM -> transmit RAM equals receive RAM; odone pulses once, 64*(17+1+1+16)+1 cycles after istart (count precisely from the istart cycle).
- Cipher stall: L=37 on word 5 plus a spurious icipher_done during LOAD -> no extra writes, data correct, total cycle count increases by exactly 36.
- Ignored start: istart re-asserted while obusy=1 -> no restart; blk continues; exactly one odone.
- Reset mid-run: irst asserted during STORE of word 10 -> next cycle owen=0, obusy=0. A new istart then completes all 64 words correctly.
